// File: rtl/register_file_mp.sv
// Multi-read-port register file with registered reads, optional hardwired x0 and a sweep-clear engine.
// Define RF_BYPASS_EN to forward same-cycle write data to reads of the same index.
module register_file_mp #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int IDXW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  output logic                 ready,
  input  logic                 wr_en,
  input  logic [IDXW-1:0]      wr_index,
  input  logic [XLEN-1:0]      wr_data,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*IDXW-1:0]  rd_index,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_valid
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
  localparam logic [IDXW:0]   DEPTH_W  = (IDXW + 1)'(DEPTH);

  state_t          state, next_state;
  logic [IDXW-1:0] cnt, next_cnt;
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_val [NRD];
  logic            wr_fire;

  function automatic logic idx_ok(input logic [IDXW-1:0] idx);
    return ({1'b0, idx} < DEPTH_W);
  endfunction

  function automatic logic idx_zero(input logic [IDXW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      INIT: begin
        next_cnt = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          next_state = RUN;
          next_cnt   = '0;
        end
      end
      RUN: begin
        if (clear) begin
          next_state = INIT;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = INIT;
        next_cnt   = '0;
      end
    endcase
  end

  assign ready   = (state == RUN);
  // A clear in the same cycle wins over the write.
  assign wr_fire = ready && wr_en && !clear && idx_ok(wr_index) && !idx_zero(wr_index);

  // NOTE: the array has no reset term; the INIT sweep zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else if (wr_fire) begin
        mem[wr_index] <= wr_data;
      end
    end
  end

  always_comb begin
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NRD; i++) begin
      idx       = rd_index[i*IDXW +: IDXW];
      rd_val[i] = '0;
      if (idx_ok(idx) && !idx_zero(idx)) begin
        rd_val[i] = mem[idx];
      end
`ifdef RF_BYPASS_EN
      if (wr_fire && (wr_index == idx)) begin
        rd_val[i] = wr_data;
      end
`endif
    end
  end

  // Reads are ignored while the sweep runs; data holds, valid drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else if (ready) begin
      for (int i = 0; i < NRD; i++) begin
        rd_valid[i] <= rd_en[i];
        if (rd_en[i]) begin
          rd_data[i*XLEN +: XLEN] <= rd_val[i];
        end
      end
    end else begin
      rd_valid <= '0;
    end
  end

endmodule
